// File: rtl/main_memory_pkg.sv
// Shared definitions for the main-memory controller slice.
//   - mm_state_t : controller FSM state encoding
//   - DEF_*      : default parameter values
//   - word_index : byte address -> word index within the array (aliases modulo depth)
package main_memory_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_REQ   = 3'd2,
    RD_DRIVE = 3'd3,
    WR_WAIT  = 3'd4,
    REL_WAIT = 3'd5
  } mm_state_t;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MEM_DEPTH_LOG2 = 10;
  localparam int DEF_RD_LATENCY     = 4;
  localparam int DEF_WR_LATENCY     = 4;

  // Drops the two byte-offset bits and keeps depth_log2 bits of word index;
  // everything above is ignored, so addresses alias modulo the depth.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input int depth_log2);
    logic [63:0] mask;
    mask = (64'd1 << depth_log2) - 64'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/main_memory_ctrl_array.sv
// Storage array for the main-memory controller.
// Single port: synchronous write, combinational read, not reset.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : word index (shared by read and write)
//   wdata_i : write data
//   rdata_o : read data at addr_i
module mm_array #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [MEM_DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<MEM_DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory controller on the common bus.
// Serves line fills (BusRd/BusRdX) after RD_LATENCY cycles by requesting the
// bus from the arbiter and driving one data beat; accepts dirty write-backs
// (Mem_wr) and commits them after WR_LATENCY cycles. A snooping cache may
// cancel a pending fill with Mem_oprn_abort. One operation at a time.
//   clk, rst           : clock, asynchronous active-high reset
//   Address_Com        : common-bus address
//   Data_Bus_Com_in    : write-back data
//   Data_Bus_Com_out/oe: read data and its drive enable (out is 0 when oe=0)
//   BusRd, BusRdX      : level read requests
//   Mem_wr             : level write-back request
//   Mem_oprn_abort     : cancel the pending read
//   Mem_snoop_req/gnt  : bus request to / grant from the arbiter
//   Data_in_Bus        : one-cycle read-data-valid pulse
//   Mem_write_done     : one-cycle write-commit pulse
module main_memory_ctrl
  import main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH_LOG2 = DEF_MEM_DEPTH_LOG2,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int WR_LATENCY     = DEF_WR_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_Com,
  input  logic [DATA_WIDTH-1:0] Data_Bus_Com_in,
  output logic [DATA_WIDTH-1:0] Data_Bus_Com_out,
  output logic                  Data_Bus_Com_oe,
  input  logic                  BusRd,
  input  logic                  BusRdX,
  input  logic                  Mem_wr,
  input  logic                  Mem_oprn_abort,
  output logic                  Mem_snoop_req,
  input  logic                  Mem_snoop_gnt,
  output logic                  Data_in_Bus,
  output logic                  Mem_write_done
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mm_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      from_wr_q, from_wr_d;
  logic [MEM_DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

  logic                      rd_req;
  logic                      mem_we;
  logic [MEM_DEPTH_LOG2-1:0] req_idx;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  assign rd_req  = BusRd | BusRdX;
  assign req_idx = MEM_DEPTH_LOG2'(word_index(64'(Address_Com), MEM_DEPTH_LOG2));

  // Control state: cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      from_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      from_wr_q <= from_wr_d;
    end
  end

  // Latched address/data are only meaningful once an operation is accepted.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    from_wr_d = from_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (Mem_wr) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_W'(WR_LATENCY);
          addr_d  = req_idx;
          wdata_d = Data_Bus_Com_in;
        end else if (rd_req) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(RD_LATENCY);
          addr_d  = req_idx;
        end
      end
      RD_WAIT: begin
        if (Mem_oprn_abort) begin
          state_d   = REL_WAIT;
          from_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // Leave as the counter reaches zero so the request is visible
          // RD_LATENCY cycles after acceptance.
          if (cnt_q == CNT_W'(1)) state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (Mem_oprn_abort) begin
          state_d   = REL_WAIT;
          from_wr_d = 1'b0;
        end else if (Mem_snoop_gnt) begin
          state_d = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        state_d   = REL_WAIT;
        from_wr_d = 1'b0;
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = REL_WAIT;
          from_wr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REL_WAIT: begin
        // A read held behind a write is served as soon as the write request
        // drops; otherwise wait for every request to clear.
        if (!Mem_wr && (!rd_req || from_wr_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Mem_snoop_req   = (state_q == RD_REQ);
    Data_Bus_Com_oe = (state_q == RD_DRIVE);
    Data_in_Bus     = (state_q == RD_DRIVE);
    Mem_write_done  = (state_q == WR_WAIT) && (cnt_q == '0);
    mem_we          = (state_q == WR_WAIT) && (cnt_q == '0);
  end

  assign Data_Bus_Com_out = Data_Bus_Com_oe ? mem_rdata : '0;

  mm_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
Main-memory controller sitting downstream of the per-processor cache wrappers and the common-bus arbiter.
- Services line fills on BusRd/BusRdX by returning data on the common data bus.
- Cancels a pending fill when a snooping cache answers instead (Mem_oprn_abort).
- Accepts dirty write-backs on Mem_wr and completes them with Mem_write_done.
- Obtains the common bus for its data return through the arbiter's memory snoop request/grant pair.

Parameters:
- ADDR_WIDTH, 32, common-bus address width.
- DATA_WIDTH, 32, word width.
- MEM_DEPTH_LOG2, 10, log2 of the number of words stored.
- RD_LATENCY, 4, cycles from read acceptance to Mem_snoop_req; must be >=1.
- WR_LATENCY, 4, cycles from write acceptance to Mem_write_done; must be >=1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Address_Com  in  ADDR_WIDTH  common-bus address.
- Data_Bus_Com_in  in  DATA_WIDTH  common-bus write-back data.
- Data_Bus_Com_out  out  DATA_WIDTH  read data driven to the common bus.
- Data_Bus_Com_oe  out  1  drive enable for Data_Bus_Com_out.
- BusRd  in  1  level read request, held until Data_in_Bus or abort.
- BusRdX  in  1  level read-exclusive request; same handling as BusRd.
- Mem_wr  in  1  level write-back request, held until Mem_write_done.
- Mem_oprn_abort  in  1  a cache supplies the data; cancel the pending read.
- Mem_snoop_req  out  1  request to the arbiter for the common bus.
- Mem_snoop_gnt  in  1  arbiter grant.
- Data_in_Bus  out  1  one-cycle pulse: read data valid on the bus.
- Mem_write_done  out  1  one-cycle pulse: write-back committed.

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0 and the FSM goes to IDLE immediately.
- The storage array is not reset.
- A write still in WR_WAIT when reset asserts is discarded and leaves the array unchanged.
- Word index is Address_Com[MEM_DEPTH_LOG2+1:2]. The upper bits are ignored, so addresses alias modulo the depth.
- FSM states are IDLE, RD_WAIT, RD_REQ, RD_DRIVE, WR_WAIT, REL_WAIT.
- IDLE:
  - If Mem_wr=1, latch the address and data, load the counter with WR_LATENCY, and go to WR_WAIT.
  - Else if BusRd or BusRdX is 1, latch the address, load the counter with RD_LATENCY, and go to RD_WAIT.
  - Mem_wr has priority when both arrive in the same cycle. The read request stays held and is served after the write.
- WR_WAIT:
  - The counter decrements once per cycle.
  - At 0: write the array, assert Mem_write_done for 1 cycle, and go to REL_WAIT.
  - Mem_oprn_abort is ignored here.
- RD_WAIT:
  - The counter decrements once per cycle. At 0, go to RD_REQ.
  - Mem_oprn_abort=1 goes to REL_WAIT with no bus activity.
- RD_REQ:
  - Mem_snoop_req=1 until the grant is seen.
  - When Mem_snoop_gnt=1, go to RD_DRIVE.
  - Mem_oprn_abort=1 drops the request and goes to REL_WAIT.
- RD_DRIVE, exactly 1 cycle:
  - Data_Bus_Com_oe=1, Data_in_Bus=1, and Data_Bus_Com_out equals the array word at the latched address.
  - Mem_snoop_req falls to 0 in this cycle.
  - Abort is ignored. Then go to REL_WAIT.
- REL_WAIT:
  - Go to IDLE once BusRd, BusRdX and Mem_wr are all 0. This prevents re-triggering on a still-held request.
  - Exception: when REL_WAIT was entered from WR_WAIT and a read is held, go directly to IDLE-service of that read once Mem_wr=0.
- Data_Bus_Com_out=0 whenever Data_Bus_Com_oe=0.
- The counter width is clog2(max(RD_LATENCY, WR_LATENCY)+1).
- Only one operation is in flight at a time. No queueing.

Decomposition:
- Package main_memory_pkg holds:
  - the state enum mm_state_t;
  - default latency constants;
  - the word-index slice macro or function.
- Sub-module mm_array: single-port, synchronous-write, combinational-read array of (1<<MEM_DEPTH_LOG2) x DATA_WIDTH.

Test Plan:
1. Write-back completion. Stimulus: Mem_wr=1, Address_Com=0x0000_0404, data 0xCAFECAFB, WR_LATENCY=4. Required response: Mem_write_done pulses 1 cycle, 4 cycles after acceptance; no Data_in_Bus; FSM returns to IDLE after Mem_wr drops.
2. Read with immediate grant. Stimulus: BusRd=1 at 0x0000_0404, Mem_snoop_gnt tied high when requested. Required response: Mem_snoop_req rises 4 cycles after acceptance; next cycle Data_in_Bus=1 and Data_Bus_Com_out=0xCAFECAFB with oe=1, each for exactly 1 cycle.
3. Aborted read. Stimulus: BusRdX=1 at 0x0000_0808, Mem_oprn_abort=1 on the 2nd cycle of RD_WAIT. Required response: Mem_snoop_req, Data_in_Bus and oe never assert; IDLE after BusRdX drops.
4. Delayed grant. Stimulus: BusRd at 0x0000_0404, gnt withheld for 5 cycles. Required response: Mem_snoop_req held 5 cycles; data is driven only in the cycle after the grant.
5. Simultaneous write and read. Stimulus: Mem_wr (0x0000_0C0C, 0xBEADBEAD) and BusRd (0x0000_0C0C) in the same cycle. Required response: Mem_write_done first; the read is then served and returns 0xBEADBEAD.
6. Reset mid-read. Stimulus: rst=1 during RD_WAIT. Required response: all outputs 0 asynchronously; after release, a new BusRd at 0x0000_0404 returns 0xCAFECAFB with normal latency.
